// File: rtl/if_id_fetch_stage_pkg.sv
// Shared definitions for the IF stage: defaults, FSM encoding, instruction
// field positions and the fetch payload carried into IF/ID.
package if_id_fetch_stage_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned RS_MSB = 25;
    localparam int unsigned RS_LSB = 21;
    localparam int unsigned RT_MSB = 20;
    localparam int unsigned RT_LSB = 16;

    localparam logic [XLEN-1:0] DEF_RESET_PC  = 32'h0000_0000;
    localparam logic [XLEN-1:0] DEF_NOP_INSTR = 32'h0000_0000;  // sll $0,$0,0

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc_plus4;
    } fetch_pkt_t;

    // Force a fetch address onto a word boundary.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return a & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/if_id_fetch_stage_if_id_reg.sv
// IF/ID pipeline register.
// Ports: clk/rst (async active-high), hold (keep contents), load (capture
// load_pkt as a real instruction); neither hold nor load inserts a bubble.
// Outputs: instr, pc_plus4, valid, and the rs/rt fields of instr.
module if_id_fetch_stage_if_id_reg
    import if_id_fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    input  logic             load,
    input  fetch_pkt_t       load_pkt,
    output logic [XLEN-1:0]  instr,
    output logic [XLEN-1:0]  pc_plus4,
    output logic             valid,
    output logic [REG_W-1:0] rs,
    output logic [REG_W-1:0] rt
);

    // Hold has priority over load; anything else becomes a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr    <= NOP_INSTR;
            pc_plus4 <= '0;
            valid    <= 1'b0;
        end else if (!hold) begin
            if (load) begin
                instr    <= load_pkt.instr;
                pc_plus4 <= load_pkt.pc_plus4;
                valid    <= 1'b1;
            end else begin
                instr    <= NOP_INSTR;
                pc_plus4 <= '0;
                valid    <= 1'b0;
            end
        end
    end

    // Register fields straight off the held instruction for the hazard unit.
    assign rs = instr[RS_MSB:RS_LSB];
    assign rt = instr[RT_MSB:RT_LSB];

endmodule

// File: rtl/if_id_fetch_stage.sv
// IF stage of the 5-stage MIPS pipeline: PC register, instruction-memory
// request handshake (REQ/HOLD/DRAIN FSM with one-entry hold buffer) and the
// IF/ID pipeline register.
// Ports: clk_i, rst_i (async active-high); stall_i, redirect_i/redirect_pc_i
// from ID/EX; imem_req_o/imem_addr_o/imem_ack_i/imem_rdata_i memory port;
// IF_ID_* registered instruction, PC+4, valid and rs/rt fields.
module if_id_fetch_stage
    import if_id_fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = DEF_RESET_PC,
    parameter logic [XLEN-1:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             stall_i,
    input  logic             redirect_i,
    input  logic [XLEN-1:0]  redirect_pc_i,
    output logic             imem_req_o,
    output logic [XLEN-1:0]  imem_addr_o,
    input  logic             imem_ack_i,
    input  logic [XLEN-1:0]  imem_rdata_i,
    output logic [XLEN-1:0]  IF_ID_instr_o,
    output logic [XLEN-1:0]  IF_ID_pc_plus4_o,
    output logic             IF_ID_valid_o,
    output logic [REG_W-1:0] IF_ID_RS_o,
    output logic [REG_W-1:0] IF_ID_RT_o
);

    fetch_state_e    state_q, state_n;
    logic [XLEN-1:0] pc_q, pc_n;
    logic [XLEN-1:0] pend_q, pend_n;
    fetch_pkt_t      buf_q, buf_n;
    logic            req_q;

    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] redir_pc;
    logic            id_hold;
    logic            id_load;
    fetch_pkt_t      id_pkt;

    assign pc_plus4 = pc_q + XLEN'(4);
    assign redir_pc = word_align(redirect_pc_i);

    // State, PC, pending redirect target, hold buffer and request flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_REQ;
            pc_q    <= RESET_PC;
            pend_q  <= RESET_PC;
            buf_q   <= '0;
            req_q   <= 1'b1;
        end else begin
            state_q <= state_n;
            pc_q    <= pc_n;
            pend_q  <= pend_n;
            buf_q   <= buf_n;
            req_q   <= (state_n != ST_HOLD);
        end
    end

    // Next-state, PC update and IF/ID control.
    always_comb begin
        state_n = state_q;
        pc_n    = pc_q;
        pend_n  = pend_q;
        buf_n   = buf_q;
        id_hold = 1'b0;
        id_load = 1'b0;
        id_pkt  = '{instr: imem_rdata_i, pc_plus4: pc_plus4};

        // IF/ID: redirect flushes, stall holds, else load what arrived or bubble.
        if (redirect_i) begin
            id_hold = 1'b0;
        end else if (stall_i) begin
            id_hold = 1'b1;
        end else if (state_q == ST_REQ && imem_ack_i) begin
            id_load = 1'b1;
        end else if (state_q == ST_HOLD) begin
            id_load = 1'b1;
            id_pkt  = buf_q;
        end

        case (state_q)
            ST_REQ: begin
                if (imem_ack_i) begin
                    if (redirect_i) begin
                        pc_n = redir_pc;
                    end else begin
                        pc_n = pc_plus4;
                        if (stall_i) begin
                            buf_n   = '{instr: imem_rdata_i, pc_plus4: pc_plus4};
                            state_n = ST_HOLD;
                        end
                    end
                end else if (redirect_i) begin
                    // Request in flight: keep the address, fetch target later.
                    pend_n  = redir_pc;
                    state_n = ST_DRAIN;
                end
            end
            ST_HOLD: begin
                if (redirect_i) begin
                    pc_n    = redir_pc;
                    state_n = ST_REQ;
                end else if (!stall_i) begin
                    state_n = ST_REQ;
                end
            end
            ST_DRAIN: begin
                if (redirect_i) begin
                    pend_n = redir_pc;
                end
                if (imem_ack_i) begin
                    // Stale data is dropped; the latest redirect target wins.
                    pc_n    = redirect_i ? redir_pc : pend_q;
                    state_n = ST_REQ;
                end
            end
            default: begin
                state_n = ST_REQ;
            end
        endcase
    end

    assign imem_req_o  = req_q;
    assign imem_addr_o = pc_q;

    if_id_fetch_stage_if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk      (clk_i),
        .rst      (rst_i),
        .hold     (id_hold),
        .load     (id_load),
        .load_pkt (id_pkt),
        .instr    (IF_ID_instr_o),
        .pc_plus4 (IF_ID_pc_plus4_o),
        .valid    (IF_ID_valid_o),
        .rs       (IF_ID_RS_o),
        .rt       (IF_ID_RT_o)
    );

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Bench for if_id_fetch_stage: per-cycle vector table with an IF/ID
// scoreboard, plus hand-written asynchronous-reset sequences.
module tb_if_id_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] id_instr;
    logic [31:0] id_pc4;
    logic        id_valid;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;

    int checks = 0;
    int errors = 0;

    if_id_fetch_stage dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .stall_i          (stall),
        .redirect_i       (redirect),
        .redirect_pc_i    (redirect_pc),
        .imem_req_o       (imem_req),
        .imem_addr_o      (imem_addr),
        .imem_ack_i       (imem_ack),
        .imem_rdata_i     (imem_rdata),
        .IF_ID_instr_o    (id_instr),
        .IF_ID_pc_plus4_o (id_pc4),
        .IF_ID_valid_o    (id_valid),
        .IF_ID_RS_o       (id_rs),
        .IF_ID_RT_o       (id_rt)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got no end, required end of test");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        ack;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
    } vec_t;

    typedef struct {
        int          row;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic s, input logic r, input logic [31:0] rpc,
                       input logic a, input logic [31:0] d, input logic er,
                       input logic [31:0] ea, input logic ev, input logic [31:0] ei,
                       input logic [31:0] ep);
        vec_t v;
        v.stall = s; v.redir = r; v.rpc = rpc; v.ack = a; v.rdata = d;
        v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_instr = ei; v.e_pc4 = ep;
        vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ifid(input string tag, input exp_t e);
        logic [31:0] w;
        w = e.instr;
        chk({tag, " valid"}, 32'(id_valid), 32'(e.valid));
        chk({tag, " instr"}, id_instr, e.instr);
        if (e.valid) begin
            chk({tag, " pc_plus4"}, id_pc4, e.pc4);
            chk({tag, " rs"}, 32'(id_rs), 32'(w[25:21]));
            chk({tag, " rt"}, 32'(id_rt), 32'(w[20:16]));
        end
    endtask

    task automatic drive(input logic s, input logic r, input logic [31:0] rpc,
                         input logic a, input logic [31:0] d);
        stall = s; redirect = r; redirect_pc = rpc; imem_ack = a; imem_rdata = d;
    endtask

    initial begin
        exp_t e;
        string tag;

        // 0-wait fetch, RS/RT decode
        add(0,0,0,1,32'h20080005,1,32'h0,1,32'h20080005,32'h4);
        add(0,0,0,1,32'h20090003,1,32'h4,1,32'h20090003,32'h8);
        add(0,0,0,1,32'h200A0007,1,32'h8,1,32'h200A0007,32'hC);
        add(0,0,0,1,32'h01095020,1,32'hC,1,32'h01095020,32'h10);
        // stall with ack -> HOLD, then release
        add(1,0,0,1,32'h8D0A0000,1,32'h10,1,32'h01095020,32'h10);
        add(1,0,0,0,0,0,0,1,32'h01095020,32'h10);
        add(0,0,0,0,0,0,0,1,32'h8D0A0000,32'h14);
        add(0,0,0,0,0,1,32'h14,0,0,0);
        // redirect coincident with ack (low bits of target ignored)
        add(0,1,32'h43,1,32'hDEADBEEF,1,32'h14,0,0,0);
        add(0,0,0,1,32'h012A4020,1,32'h40,1,32'h012A4020,32'h44);
        // 3 wait states, redirect in wait cycle 1 -> DRAIN
        add(0,1,32'h80,0,0,1,32'h44,0,0,0);
        add(0,0,0,0,0,1,32'h44,0,0,0);
        add(0,0,0,0,0,1,32'h44,0,0,0);
        add(0,0,0,1,32'hCAFEF00D,1,32'h44,0,0,0);
        add(0,0,0,0,0,1,32'h80,0,0,0);
        add(0,0,0,1,32'h8D0B0004,1,32'h80,1,32'h8D0B0004,32'h84);
        // second redirect during DRAIN: latest target wins
        add(0,1,32'h100,0,0,1,32'h84,0,0,0);
        add(0,1,32'hC0,0,0,1,32'h84,0,0,0);
        add(0,0,0,1,32'h12345678,1,32'h84,0,0,0);
        add(0,0,0,1,32'h00A42820,1,32'hC0,1,32'h00A42820,32'hC4);
        // stall over a bubble; redirect beats stall in HOLD
        add(0,0,0,0,0,1,32'hC4,0,0,0);
        add(1,0,0,0,0,1,32'hC4,0,0,0);
        add(1,0,0,1,32'hAAAA0000,1,32'hC4,0,0,0);
        add(1,1,32'h200,0,0,0,0,0,0,0);
        add(0,0,0,1,32'h03E00008,1,32'h200,1,32'h03E00008,32'h204);
        // PC wrap
        add(0,1,32'hFFFFFFFE,1,32'h11110000,1,32'h204,0,0,0);
        add(0,0,0,1,32'h24420001,1,32'hFFFFFFFC,1,32'h24420001,32'h0);
        add(0,0,0,0,0,1,32'h0,0,0,0);

        // reset state
        tick();
        tick();
        chk("reset valid", 32'(id_valid), 32'h0);
        chk("reset instr", id_instr, 32'h0);
        chk("reset pc_plus4", id_pc4, 32'h0);
        rst = 1'b0;
        chk("reset req", 32'(imem_req), 32'h1);

        foreach (vecs[i]) begin
            tag = $sformatf("row%0d", i);
            if (vecs[i].e_req) chk({tag, " addr"}, imem_addr, vecs[i].e_addr);
            chk({tag, " req"}, 32'(imem_req), 32'(vecs[i].e_req));
            drive(vecs[i].stall, vecs[i].redir, vecs[i].rpc, vecs[i].ack, vecs[i].rdata);
            e.row = i; e.valid = vecs[i].e_valid; e.instr = vecs[i].e_instr; e.pc4 = vecs[i].e_pc4;
            sb.push_back(e);
            tick();
            if (sb.size() == 0) begin
                chk({tag, " scoreboard empty"}, 32'h0, 32'h1);
            end else begin
                e = sb.pop_front();
                check_ifid($sformatf("row%0d", e.row), e);
            end
        end

        // async reset mid-HOLD
        chk("hA addr", imem_addr, 32'h0);
        drive(0,0,0,1,32'h20080005);
        tick();
        e.valid = 1; e.instr = 32'h20080005; e.pc4 = 32'h4;
        check_ifid("hA load", e);
        drive(1,0,0,1,32'h8C880000);
        tick();
        chk("hA in hold req", 32'(imem_req), 32'h0);
        #2 rst = 1'b1;
        #1;
        chk("hA rst valid", 32'(id_valid), 32'h0);
        chk("hA rst instr", id_instr, 32'h0);
        chk("hA rst pc_plus4", id_pc4, 32'h0);
        chk("hA rst req", 32'(imem_req), 32'h1);
        chk("hA rst addr", imem_addr, 32'h0);
        drive(0,0,0,0,0);
        @(negedge clk) rst = 1'b0;
        tick();
        e.valid = 0; e.instr = 32'h0; e.pc4 = 32'h0;
        check_ifid("hA no buffer", e);
        chk("hA first addr", imem_addr, 32'h0);
        drive(0,0,0,1,32'h11112222);
        tick();
        e.valid = 1; e.instr = 32'h11112222; e.pc4 = 32'h4;
        check_ifid("hA refetch", e);

        // async reset mid-DRAIN
        chk("dB addr", imem_addr, 32'h4);
        drive(0,1,32'h300,0,0);
        tick();
        chk("dB drain req", 32'(imem_req), 32'h1);
        chk("dB drain addr", imem_addr, 32'h4);
        #2 rst = 1'b1;
        #1;
        chk("dB rst addr", imem_addr, 32'h0);
        chk("dB rst valid", 32'(id_valid), 32'h0);
        drive(0,0,0,0,0);
        @(negedge clk) rst = 1'b0;
        tick();
        chk("dB first req", 32'(imem_req), 32'h1);
        chk("dB first addr", imem_addr, 32'h0);
        drive(0,0,0,1,32'h22223333);
        tick();
        e.valid = 1; e.instr = 32'h22223333; e.pc4 = 32'h4;
        check_ifid("dB refetch", e);
        chk("dB next addr", imem_addr, 32'h4);
        drive(0,0,0,0,0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
